// File: rtl/instruction_encoder.sv
// Instruction encoder: packs opcode/field tuples into 16-bit words and queues
// legal words, each tagged with a sequential word address; illegal tuples are
// consumed, dropped and reported through the err_* outputs.
module instruction_encoder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned ERRCNT_W   = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [3:0]                         in_opcode,
   input  logic [2:0]                         in_rd,
   input  logic [2:0]                         in_rs1,
   input  logic [2:0]                         in_rs2,
   input  logic [6:0]                         in_imm,
   input  logic [5:0]                         in_nzimm,
   input  logic [8:0]                         in_offset,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [15:0]                        out_instr,
   output logic [ADDR_W-1:0]                  out_addr,
   output logic                               err_valid,
   output logic [3:0]                         err_opcode,
   output logic [ERRCNT_W-1:0]                err_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_st_t;

   fifo_st_t           st_q, st_nxt;
   logic [15:0]        mem_instr [FIFO_DEPTH];
   logic [ADDR_W-1:0]  mem_addr  [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_nxt;
   logic [ADDR_W-1:0]  addr_cnt;
   logic [LVL_W-1:0]   lvl_nxt, remain;

   logic               legal;
   logic [15:0]        word;
   logic               accept, push, drop, pop;
   logic [15:0]        head_instr_nxt;
   logic [ADDR_W-1:0]  head_addr_nxt;

   // Field packing and legality check for the presented tuple
   always_comb begin
      legal = 1'b0;
      word  = 16'h0000;
      case (in_opcode)
         4'b0010, 4'b0100, 4'b0110, 4'b0111: begin
            legal = 1'b1;
            word  = {in_opcode, in_rd, in_rs1, in_rs2, 3'b000};
         end
         4'b0000, 4'b0001, 4'b0101: begin
            legal = 1'b1;
            word  = {in_opcode, in_rd, 2'b00, in_imm};
         end
         4'b0011, 4'b1000, 4'b1001: begin
            legal = (in_nzimm != 6'd0);
            word  = {in_opcode, in_rd, in_rs1, in_nzimm};
         end
         4'b1010, 4'b1011: begin
            legal = 1'b1;
            word  = {in_opcode, in_rs1, in_offset};
         end
         default: begin
            legal = 1'b0;
            word  = 16'h0000;
         end
      endcase
   end

   // Handshake decode and next FIFO occupancy / state / head
   always_comb begin
      accept = in_valid && (st_q != ST_FULL);
      push   = accept && legal;
      drop   = accept && !legal;
      pop    = (st_q != ST_EMPTY) && out_ready;

      lvl_nxt = fifo_level;
      if (push && !pop) begin
         lvl_nxt = fifo_level + LVL_W'(1);
      end else if (!push && pop) begin
         lvl_nxt = fifo_level - LVL_W'(1);
      end

      st_nxt = ST_PARTIAL;
      if (lvl_nxt == '0) begin
         st_nxt = ST_EMPTY;
      end else if (lvl_nxt == LVL_W'(FIFO_DEPTH)) begin
         st_nxt = ST_FULL;
      end

      rd_nxt = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
      remain = pop ? (fifo_level - LVL_W'(1)) : fifo_level;

      // The head is either an entry already stored or, if nothing older
      // remains, the word being pushed this cycle; empty holds the last value.
      head_instr_nxt = out_instr;
      head_addr_nxt  = out_addr;
      if (lvl_nxt != '0) begin
         if (push && (remain == '0)) begin
            head_instr_nxt = word;
            head_addr_nxt  = addr_cnt;
         end else begin
            head_instr_nxt = mem_instr[rd_nxt];
            head_addr_nxt  = mem_addr[rd_nxt];
         end
      end
   end

   // FIFO storage array, written at the tail on every legal accept
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= word;
         mem_addr[wr_ptr]  <= addr_cnt;
      end
   end

   // Control state, pointers, registered outputs and error reporting
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= ST_EMPTY;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         addr_cnt   <= '0;
         fifo_level <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_instr  <= 16'h0000;
         out_addr   <= '0;
         err_valid  <= 1'b0;
         err_opcode <= 4'h0;
         err_count  <= '0;
      end else begin
         st_q       <= st_nxt;
         rd_ptr     <= rd_nxt;
         fifo_level <= lvl_nxt;
         in_ready   <= (st_nxt != ST_FULL);
         out_valid  <= (st_nxt != ST_EMPTY);
         out_instr  <= head_instr_nxt;
         out_addr   <= head_addr_nxt;
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            addr_cnt <= addr_cnt + ADDR_W'(1);
         end
         err_valid <= drop;
         if (drop) begin
            err_opcode <= in_opcode;
            if (err_count != '1) begin
               err_count <= err_count + ERRCNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: directed scenarios plus a randomized
// stream, every cycle compared against a queue-based reference model.
module tb_instruction_encoder;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [2:0]  in_rd, in_rs1, in_rs2;
   logic [6:0]  in_imm;
   logic [5:0]  in_nzimm;
   logic [8:0]  in_offset;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_addr;
   logic        err_valid;
   logic [3:0]  err_opcode;
   logic [7:0]  err_count;
   logic [2:0]  fifo_level;

   instruction_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .in_nzimm   (in_nzimm),
      .in_offset  (in_offset),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .err_valid  (err_valid),
      .err_opcode (err_opcode),
      .err_count  (err_count),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct {
      logic [15:0] w;
      logic [7:0]  a;
   } ent_t;
   ent_t        q[$];
   int          m_addr;
   logic [15:0] m_last_w;
   logic [7:0]  m_last_a;
   bit          m_ev;
   logic [3:0]  m_eop;
   int          m_ecnt;

   // Encoding from the format table, built with plain arithmetic
   function automatic bit ref_encode(input int op, input int rd, input int rs1, input int rs2,
                                     input int imm, input int nz, input int off,
                                     output logic [15:0] w);
      int v;
      bit ok;
      ok = 1'b1;
      v  = 0;
      if (op inside {2, 4, 6, 7})       v = op * 4096 + rd * 512 + rs1 * 64 + rs2 * 8;
      else if (op inside {0, 1, 5})     v = op * 4096 + rd * 512 + imm;
      else if (op inside {3, 8, 9}) begin
         v  = op * 4096 + rd * 512 + rs1 * 64 + nz;
         ok = (nz != 0);
      end
      else if (op inside {10, 11})      v = op * 4096 + rs1 * 512 + off;
      else                              ok = 1'b0;
      w = v[15:0];
      return ok;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge
   task automatic model_step();
      logic [15:0] w;
      ent_t        e;
      bit          acc, popn;
      if (rst) begin
         q.delete();
         m_addr   = 0;
         m_last_w = '0;
         m_last_a = '0;
         m_ev     = 1'b0;
         m_eop    = '0;
         m_ecnt   = 0;
      end else begin
         acc  = in_valid && (q.size() < DEPTH);
         popn = (q.size() > 0) && out_ready;
         m_ev = 1'b0;
         if (popn) begin
            e        = q.pop_front();
            m_last_w = e.w;
            m_last_a = e.a;
         end
         if (acc) begin
            if (ref_encode(int'(in_opcode), int'(in_rd), int'(in_rs1), int'(in_rs2),
                           int'(in_imm), int'(in_nzimm), int'(in_offset), w)) begin
               e.w = w;
               e.a = 8'(m_addr);
               q.push_back(e);
               m_addr = (m_addr + 1) % 256;
            end else begin
               m_ev  = 1'b1;
               m_eop = in_opcode;
               if (m_ecnt < 255) m_ecnt++;
            end
         end
      end
   endtask

   // Compare every DUT output against the model
   task automatic check_all();
      logic [15:0] ew;
      logic [7:0]  ea;
      ew = (q.size() != 0) ? q[0].w : m_last_w;
      ea = (q.size() != 0) ? q[0].a : m_last_a;
      chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
      chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("out_instr",  32'(out_instr),  32'(ew));
      chk("out_addr",   32'(out_addr),   32'(ea));
      chk("err_valid",  32'(err_valid),  32'(m_ev));
      chk("err_opcode", 32'(err_opcode), 32'(m_eop));
      chk("err_count",  32'(err_count),  32'(m_ecnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input int nz, input int off);
      in_valid  = v;
      in_opcode = 4'(op);
      in_rd     = 3'(rd);
      in_rs1    = 3'(rs1);
      in_rs2    = 3'(rs2);
      in_imm    = 7'(imm);
      in_nzimm  = 6'(nz);
      in_offset = 9'(off);
   endtask

   task automatic drive_rand(input bit v);
      int nz;
      nz = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
      drive(v, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), nz,
            int'($urandom_range(0, 511)));
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", 32'(out_instr), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);

      // Single I-type word, latency one
      drive(1, 0, 2, 0, 0, 10, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_instr", 32'(out_instr), 32'h040A);
      chk("t1_addr",  32'(out_addr),  32'd0);
      out_ready = 1'b1;
      step();

      // NZ, R and B words streamed with the consumer ready
      pulse_rst();
      drive(1, 3, 1, 2, 0, 0, 10, 0);
      step();
      chk("t2_instr0", 32'(out_instr), 32'h328A);
      chk("t2_addr0",  32'(out_addr),  32'd0);
      drive(1, 2, 1, 2, 3, 0, 0, 0);
      step();
      chk("t2_instr1", 32'(out_instr), 32'h2298);
      chk("t2_addr1",  32'(out_addr),  32'd1);
      drive(1, 10, 0, 0, 0, 0, 0, 10);
      step();
      chk("t2_instr2", 32'(out_instr), 32'hA00A);
      chk("t2_addr2",  32'(out_addr),  32'd2);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Two illegal tuples back to back, then a legal one
      pulse_rst();
      drive(1, 3, 1, 2, 0, 0, 0, 0);
      step();
      chk("t3_ev0",  32'(err_valid),  32'd1);
      chk("t3_eop0", 32'(err_opcode), 32'h3);
      drive(1, 12, 0, 0, 0, 0, 0, 0);
      step();
      chk("t3_ev1",  32'(err_valid),  32'd1);
      chk("t3_eop1", 32'(err_opcode), 32'hC);
      chk("t3_ecnt", 32'(err_count),  32'd2);
      chk("t3_noval", 32'(out_valid), 32'd0);
      drive(1, 1, 5, 0, 0, 99, 0, 0);
      step();
      chk("t3_addr", 32'(out_addr), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Fill to full with the consumer stalled, then drain
      pulse_rst();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, i, 0, 0, i, 0, 0);
         step();
      end
      drive(1, 0, 4, 0, 0, 4, 0, 0);
      chk("t4_full_rdy", 32'(in_ready),   32'd0);
      chk("t4_full_lvl", 32'(fifo_level), 32'd4);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      chk("t4_lvl_after", 32'(fifo_level), 32'd4);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("t4_addr_seq", 32'(out_addr), 32'(k));
         step();
      end
      chk("t4_empty", 32'(fifo_level), 32'd0);

      // Address counter wrap with continuous push and pop
      pulse_rst();
      for (int k = 0; k <= 256; k++) begin
         drive(1, 5, k % 8, 0, 0, k % 128, 0, 0);
         step();
         chk("wrap_addr", 32'(out_addr), 32'(k % 256));
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Mid-stream reset discards queued words and restarts the address
      pulse_rst();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 11, i, i, 0, 0, 0, i + 7);
         step();
      end
      chk("t6_lvl3", 32'(fifo_level), 32'd3);
      pulse_rst();
      chk("t6_lvl0",  32'(fifo_level), 32'd0);
      chk("t6_noval", 32'(out_valid),  32'd0);
      drive(1, 6, 1, 2, 3, 0, 0, 0);
      step();
      chk("t6_addr0", 32'(out_addr), 32'd0);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(1, 12 + (i % 4), 0, 0, 0, 0, 0, 0);
         step();
      end
      chk("t6_sat", 32'(err_count), 32'hFF);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      pulse_rst();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         drive_rand(($urandom_range(0, 3) != 0));
         out_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
